// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: one column per tick, 2-flop row sync,
// whole-frame debounce, one-cycle press/release strobes and a held flag.
module keypad_scanner #(
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1khz,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_held
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

  logic [3:0]  row_m, row_s;
  logic [1:0]  col_idx;
  logic [15:0] frame, cur;
  logic [4:0]  n_down;
  logic [3:0]  key_idx;
  logic        frame_done, none, single;
  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n, cand, cand_n;
  logic        accept, rel;

  // Row sync, column drive and per-column frame capture (bit index = row*4+col)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_m   <= 4'b1111;
      row_s   <= 4'b1111;
      col_idx <= 2'd0;
      col     <= 4'b1110;
      frame   <= '0;
    end else begin
      row_m <= row;
      row_s <= row_m;
      if (tick_1khz) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (col_idx == 2'(c)) frame[4*r+c] <= ~row_s[r];
        col_idx <= col_idx + 2'd1;
        col     <= ~(4'b0001 << (col_idx + 2'd1));
      end
    end
  end

  // Completed frame view: stored cols 0..2 plus the live col 3 sample
  always_comb begin
    cur = frame;
    for (int r = 0; r < 4; r++) cur[4*r+3] = ~row_s[r];
  end

  always_comb begin
    n_down  = 5'd0;
    key_idx = 4'd0;
    for (int i = 0; i < 16; i++)
      if (cur[i]) begin
        n_down  = n_down + 5'd1;
        key_idx = 4'(i);
      end
  end

  assign frame_done = tick_1khz && (col_idx == 2'd3);
  assign none       = (n_down == 5'd0);
  assign single     = (n_down == 5'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      cand        <= 4'd0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cand        <= cand_n;
      key_valid   <= accept;
      key_release <= rel;
      if (accept) begin
        key_code <= key_idx;
        key_held <= 1'b1;
      end else if (rel) begin
        key_held <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    if (frame_done) begin
      case (state)
        IDLE:
          if (single) begin
            cand_n = key_idx;
            if (DF == 4'd1) begin
              state_n = HELD;
              cnt_n   = 4'd0;
            end else begin
              state_n = PRESS_WAIT;
              cnt_n   = 4'd1;
            end
          end
        PRESS_WAIT:
          if (single && key_idx == cand) begin
            cnt_n = cnt + 4'd1;
            if (cnt + 4'd1 == DF) state_n = HELD;
          end else if (single) begin
            cand_n = key_idx;
            cnt_n  = 4'd1;
          end else begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end
        HELD:
          if (none) begin
            if (DF == 4'd1) begin
              state_n = IDLE;
              cnt_n   = 4'd0;
            end else begin
              state_n = RELEASE_WAIT;
              cnt_n   = 4'd1;
            end
          end
        RELEASE_WAIT:
          if (none) begin
            if (cnt + 4'd1 == DF) begin
              state_n = IDLE;
              cnt_n   = 4'd0;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end else begin
            state_n = HELD;
            cnt_n   = 4'd0;
          end
        default: state_n = IDLE;
      endcase
    end
  end

  // Entering HELD from the press side is an accept; entering IDLE from the release side is a release
  always_comb begin
    accept = frame_done && (state_n == HELD) && (state == IDLE || state == PRESS_WAIT);
    rel    = frame_done && (state_n == IDLE) && (state == HELD || state == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a matrix model closes row lines against
// the driven column, and each scenario checks strobe counts at frame boundaries.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1khz = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid, key_release, key_held;

  logic [15:0] pressed = '0;
  logic [1:0]  tdiv = 2'd3;
  int          vcnt = 0, rcnt = 0;
  logic        both = 1'b0;
  int          tests = 0, fails = 0;

  keypad_scanner #(.DEBOUNCE_FRAMES(5)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1khz(tick_1khz), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_release(key_release),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Scan tick every 4 clocks, updated just after the edge
  always @(posedge clk) begin
    #1;
    tdiv      = tdiv + 2'd1;
    tick_1khz = (tdiv == 2'd0);
  end

  // Key at (r,c) shorts row r to column c
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[4*r +: 4] & ~col);
  end

  always @(negedge clk) begin
    if (key_valid)   vcnt <= vcnt + 1;
    if (key_release) rcnt <= rcnt + 1;
    if (key_valid && key_release) both <= 1'b1;
  end

  // Returns just after the negedge following a frame-completing tick
  task automatic wait_frames(input int n);
    for (int f = 0; f < n; f++) begin
      int guard = 0;
      @(negedge clk);
      while (!(tick_1khz && col == 4'b0111) && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        tests++; fails++;
        $display("FAIL frame_timeout: got no frame end within %0d cycles, required one", guard);
      end
      @(posedge clk); #2;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_col [4];
    exp_col[0] = 4'b1101; exp_col[1] = 4'b1011; exp_col[2] = 4'b0111; exp_col[3] = 4'b1110;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (col !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 ||
          key_release !== 1'b0 || key_held !== 1'b0) begin
        fails++;
        $display("FAIL reset_state: got col=%b code=%0d v=%b r=%b h=%b, required col=1110 and zeros",
                 col, key_code, key_valid, key_release, key_held);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int guard = 0;
      while (!tick_1khz && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk); #2;
      tests++;
      if (col !== exp_col[i]) begin
        fails++;
        $display("FAIL col_step%0d: got %b, required %b", i, col, exp_col[i]);
      end
    end
  endtask

  task automatic test_clean_press;
    int v0;
    wait_frames(1);
    v0 = vcnt;
    pressed = 16'h1 << 9;
    wait_frames(4);
    tests++;
    if (vcnt !== v0) begin
      fails++; $display("FAIL press_early: got %0d pulses, required 0", vcnt - v0);
    end
    wait_frames(1);
    tests++;
    if (vcnt !== v0 + 1 || key_code !== 4'd9 || key_held !== 1'b1) begin
      fails++;
      $display("FAIL press_accept: got pulses=%0d code=%0d held=%b, required 1/9/1",
               vcnt - v0, key_code, key_held);
    end
    wait_frames(3);
    tests++;
    if (vcnt !== v0 + 1 || key_held !== 1'b1) begin
      fails++; $display("FAIL press_no_repeat: got pulses=%0d held=%b, required 1/1", vcnt - v0, key_held);
    end
  endtask

  task automatic test_release;
    int r0, v0;
    r0 = rcnt; v0 = vcnt;
    pressed = '0;
    wait_frames(3);
    pressed = 16'h1 << 9;
    wait_frames(1);
    pressed = '0;
    wait_frames(4);
    tests++;
    if (rcnt !== r0 || key_held !== 1'b1) begin
      fails++; $display("FAIL release_early: got rel=%0d held=%b, required 0/1", rcnt - r0, key_held);
    end
    wait_frames(1);
    tests++;
    if (rcnt !== r0 + 1 || key_held !== 1'b0 || key_code !== 4'd9 || vcnt !== v0) begin
      fails++;
      $display("FAIL release_accept: got rel=%0d held=%b code=%0d presses=%0d, required 1/0/9/0",
               rcnt - r0, key_held, key_code, vcnt - v0);
    end
    wait_frames(1);
    tests++;
    if (rcnt !== r0 + 1) begin
      fails++; $display("FAIL release_single: got %0d releases, required 1", rcnt - r0);
    end
  endtask

  task automatic test_bounce;
    int v0, r0;
    v0 = vcnt;
    pressed = 16'h1 << 9;
    wait_frames(2);
    pressed = '0;
    wait_frames(1);
    tests++;
    if (vcnt !== v0) begin
      fails++; $display("FAIL bounce_gap: got %0d pulses, required 0", vcnt - v0);
    end
    pressed = 16'h1 << 9;
    wait_frames(4);
    tests++;
    if (vcnt !== v0 || key_held !== 1'b0) begin
      fails++; $display("FAIL bounce_early: got pulses=%0d held=%b, required 0/0", vcnt - v0, key_held);
    end
    wait_frames(1);
    tests++;
    if (vcnt !== v0 + 1 || key_code !== 4'd9 || key_held !== 1'b1) begin
      fails++;
      $display("FAIL bounce_accept: got pulses=%0d code=%0d held=%b, required 1/9/1", vcnt - v0, key_code, key_held);
    end
    wait_frames(1);
    r0 = rcnt;
    pressed = '0;
    wait_frames(5);
    tests++;
    if (rcnt !== r0 + 1 || key_held !== 1'b0) begin
      fails++; $display("FAIL bounce_release: got rel=%0d held=%b, required 1/0", rcnt - r0, key_held);
    end
  endtask

  task automatic test_multi;
    int v0, r0;
    v0 = vcnt;
    pressed = (16'h1 << 0) | (16'h1 << 15);
    wait_frames(10);
    tests++;
    if (vcnt !== v0 || key_held !== 1'b0) begin
      fails++; $display("FAIL multi_reject: got pulses=%0d held=%b, required 0/0", vcnt - v0, key_held);
    end
    pressed = 16'h1 << 0;
    wait_frames(4);
    tests++;
    if (vcnt !== v0) begin
      fails++; $display("FAIL multi_early: got %0d pulses, required 0", vcnt - v0);
    end
    wait_frames(1);
    tests++;
    if (vcnt !== v0 + 1 || key_code !== 4'd0 || key_held !== 1'b1) begin
      fails++;
      $display("FAIL multi_accept: got pulses=%0d code=%0d held=%b, required 1/0/1", vcnt - v0, key_code, key_held);
    end
    r0 = rcnt;
    pressed = '0;
    wait_frames(5);
    tests++;
    if (rcnt !== r0 + 1 || key_code !== 4'd0) begin
      fails++; $display("FAIL multi_release: got rel=%0d code=%0d, required 1/0", rcnt - r0, key_code);
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = vcnt;
    pressed = 16'h1 << 6;
    wait_frames(3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (col !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'd0) begin
      fails++;
      $display("FAIL mid_reset_clear: got col=%b v=%b h=%b code=%0d, required 1110/0/0/0",
               col, key_valid, key_held, key_code);
    end
    wait_frames(4);
    tests++;
    if (vcnt !== v0) begin
      fails++; $display("FAIL mid_reset_early: got %0d pulses, required 0", vcnt - v0);
    end
    wait_frames(1);
    tests++;
    if (vcnt !== v0 + 1 || key_code !== 4'd6 || key_held !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_accept: got pulses=%0d code=%0d held=%b, required 1/6/1", vcnt - v0, key_code, key_held);
    end
  endtask

  task automatic test_strobe_exclusive;
    tests++;
    if (both !== 1'b0) begin
      fails++; $display("FAIL strobe_overlap: got both=%b, required 0", both);
    end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_release;
    test_bounce;
    test_multi;
    test_reset_mid;
    test_strobe_exclusive;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side counterpart to the board's multiplexed 7-segment output driver. Scans a 4x4 active-low matrix keypad one column per tick_1khz and synchronises the row lines. Debounces over whole scan frames and reports each debounced press as a 4-bit key code with one-cycle press and release strobes. Sits next to the display driver, and its events feed the top-level input logic.

Parameters:
DEBOUNCE_FRAMES, 5, number of consecutive identical scan frames required to accept a press or a release. One frame is 4 ticks, so the default is 20 ms. Legal range is 1..15.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset; sampled on posedge clk
tick_1khz  input  1  single-cycle scan enable, spaced at least 3 clk cycles apart
row  input  4  keypad rows, active-low with external pull-ups, asynchronous
col  output  4  column drive, active-low, exactly one bit low at all times
key_code  output  4  last accepted key, code = row_index*4 + col_index
key_valid  output  1  one-cycle pulse when a press is accepted
key_release  output  1  one-cycle pulse when a release is accepted
key_held  output  1  high from accepted press until accepted release

Behaviour:
- Reset (rst_n low at a posedge clk):
  - col=4'b1110, col_idx=0, frame buffer cleared.
  - Synchroniser flops=4'b1111.
  - State=IDLE, cnt=0, cand=0.
  - key_code=0, key_valid=0, key_release=0, key_held=0.
  - Reset overrides tick_1khz in the same cycle.
- Row input: 2-flop synchroniser per row bit (row_s). A row bit is pressed when row_s bit=0.
- Scan, only on cycles with tick_1khz=1:
  - Store ~row_s into frame bits for the current col_idx.
  - col_idx <= col_idx+1, wrapping 3->0.
  - col <= ~(4'b1 << next col_idx).
  - Each column is driven for one full tick period before it is sampled.
  - No change on non-tick cycles.
- Frame completion: the tick on which col_idx==3 completes a frame. It is evaluated combinationally from stored bits for cols 0..2 plus the current sample for col 3.
- Frame classification:
  - NONE: 0 keys down.
  - SINGLE(k): exactly 1 key down, where k = row*4+col.
  - MULTI: 2 or more keys down.
- FSM, advances only on frame-completion ticks; cnt is 4 bits:
  - IDLE:
    - SINGLE(k): cand<=k, cnt<=1, go to PRESS_WAIT.
    - With DEBOUNCE_FRAMES==1, accept immediately: perform the acceptance actions and go to HELD.
    - Otherwise stay.
  - PRESS_WAIT:
    - SINGLE(cand): cnt<=cnt+1.
    - When cnt+1==DEBOUNCE_FRAMES, accept: key_code<=cand, key_valid pulse, key_held<=1, go to HELD.
    - SINGLE(other): cand<=other, cnt<=1.
    - NONE or MULTI: cnt<=0, go to IDLE.
  - HELD:
    - NONE: cnt<=1, go to RELEASE_WAIT. With DEBOUNCE_FRAMES==1, release immediately.
    - SINGLE (any key) or MULTI: stay. No auto-repeat, and no new key is accepted without a release first.
  - RELEASE_WAIT:
    - NONE: cnt<=cnt+1.
    - When cnt+1==DEBOUNCE_FRAMES: key_release pulse, key_held<=0, cnt<=0, go to IDLE.
    - Any key down: cnt<=0, go to HELD. No strobes.
- Strobes:
  - key_valid and key_release are registered and high for exactly the one clk cycle after the frame-completing tick edge.
  - Otherwise they are 0. They are never high together.
- key_code holds its value until the next accepted press. It is unchanged on release.
- Latency: press to key_valid is DEBOUNCE_FRAMES frames, plus up to 1 frame of alignment, plus 2 clk of synchronisation.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with ticks running -> col=1110 throughout, all key outputs 0. After release, col steps through 1101, 1011, 0111, 1110 on successive ticks.
2. Clean press: model pulls row2 low only while col1 is driven (k=9), held 8 frames -> exactly one key_valid pulse at the end of frame 5, key_code=9, key_held=1, no further pulses.
3. Bounce: key 9 down 2 frames, up 1 frame, down 6 frames -> no pulse during the bounce; single key_valid 5 frames after the re-press.
4. Release: from HELD, release for 3 frames, press for 1, release for 6 -> no key_release during the first gap; key_release at the end of the 5th frame of the final release; key_held=0; key_code still 9.
5. Multi-key: keys 0 and 15 down together for 10 frames -> no key_valid, key_held=0. Then release key 15 -> key 0 is accepted 5 frames later, key_code=0.
6. Reset mid-debounce: key 6 down, rst_n=0 for one cycle after frame 3 -> outputs cleared. key_valid arrives 5 full frames after reset, not 2.
